// File: rtl/riscv_ctrl_pkg.sv
// Shared control definitions for the instruction sequencer: RV32I major
// opcodes, immediate-decoder select encodings and the sequencer FSM states.
package riscv_ctrl_pkg;

    // RV32I major opcodes (instr[6:0]).
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Immediate decoder select. IMM_U is reserved: U-type instructions use
    // IMM_U_SLL so the decoder shifts the 20-bit field into place itself.
    localparam logic [2:0] IMM_I     = 3'b000;
    localparam logic [2:0] IMM_S     = 3'b001;
    localparam logic [2:0] IMM_B     = 3'b010;
    localparam logic [2:0] IMM_U     = 3'b011;
    localparam logic [2:0] IMM_J     = 3'b100;
    localparam logic [2:0] IMM_U_SLL = 3'b101;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEMWAIT,
        WB,
        HALT
    } state_e;

    // Instruction fetch is word-aligned; drop the byte offset of a target.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/opcode_class.sv
// Combinational opcode classifier: maps a major opcode to the immediate
// select and the control attributes the sequencer needs.
module opcode_class
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [2:0] imm_sel,
    output logic       is_mem,
    output logic       is_jump,
    output logic       is_branch,
    output logic       writes_rd,
    output logic       illegal
);

    // Decode table; unlisted opcodes are flagged illegal and select IMM_I.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case can infer a latch.
        imm_sel   = IMM_I;
        is_mem    = 1'b0;
        is_jump   = 1'b0;
        is_branch = 1'b0;
        writes_rd = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OPC_LOAD: begin
                is_mem    = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_OP_IMM, OPC_OP: begin
                writes_rd = 1'b1;
            end
            OPC_JALR: begin
                is_jump   = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_STORE: begin
                imm_sel = IMM_S;
                is_mem  = 1'b1;
            end
            OPC_BRANCH: begin
                imm_sel   = IMM_B;
                is_branch = 1'b1;
            end
            OPC_JAL: begin
                imm_sel   = IMM_J;
                is_jump   = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm_sel   = IMM_U_SLL;
                writes_rd = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> [MEMWAIT] ->
// WB. Owns the PC, the fetch handshake and the latched instruction.
// Optional feature macro ILLEGAL_TRAP_EN: when defined, an illegal opcode or
// a misaligned taken target parks the FSM in HALT with trap raised until
// reset. When undefined, illegal opcodes act as NOPs, target byte offsets
// are dropped and trap is tied low.
module instr_sequencer
    import riscv_ctrl_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [2:0]  imm_sel,
    output logic [31:0] pc,
    input  logic [31:0] target_addr,
    input  logic        branch_taken,
    output logic        mem_start,
    input  logic        mem_done,
    output logic        reg_we,
    output logic        trap
);

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        req_q, req_d;

    logic        is_mem, is_jump, is_branch, writes_rd, illegal;
    logic        take_target;
    logic        misaligned;

    // The latched instruction is stable from DECODE through WB, so the
    // classification (and imm_sel) needs no register of its own.
    opcode_class u_opcode_class (
        .opcode    (instr_q[6:0]),
        .imm_sel   (imm_sel),
        .is_mem    (is_mem),
        .is_jump   (is_jump),
        .is_branch (is_branch),
        .writes_rd (writes_rd),
        .illegal   (illegal)
    );

    assign take_target = is_jump || (is_branch && branch_taken);
    assign misaligned  = (target_addr[1:0] != 2'b00);

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign instr     = instr_q;
    assign trap      = TRAP_EN && (state_q == HALT);

    // State, PC, instruction and fetch-request registers; synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= PC_RESET;
            instr_q <= '0;
            req_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            req_q   <= req_d;
        end
    end

    // Next-state, PC update and single-cycle control pulses.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        req_d     = req_q;
        mem_start = 1'b0;
        reg_we    = 1'b0;
        case (state_q)
            FETCH: begin
                // Request is registered, so it rises one edge after reset;
                // an ack while the request is low is not a handshake.
                if (!req_q) begin
                    req_d = 1'b1;
                end else if (imem_ack) begin
                    instr_d = imem_rdata;
                    req_d   = 1'b0;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (TRAP_EN && illegal) begin
                    state_d = HALT;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (is_mem) begin
                    mem_start = 1'b1;
                    state_d   = MEMWAIT;
                end else begin
                    state_d = WB;
                end
            end
            MEMWAIT: begin
                if (mem_done) begin
                    state_d = WB;
                end
            end
            WB: begin
                if (TRAP_EN && take_target && misaligned) begin
                    state_d = HALT;
                end else begin
                    reg_we  = writes_rd;
                    pc_d    = take_target ? word_align(target_addr) : pc_q + 32'd4;
                    req_d   = 1'b1;
                    state_d = FETCH;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

endmodule
